// File: rtl/ahb_lite_arb_2to1_pkg.sv
// Shared types and constants for the two-port AHB-Lite arbiter.
package ahb_lite_arb_2to1_pkg;

    localparam int unsigned AHB_ADDR_W = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef struct packed {
        logic [AHB_ADDR_W-1:0] addr;
        logic                  write;
        logic [2:0]            size;
        logic [3:0]            prot;
    } ahb_addr_req_t;

    // Returns the winning port index; pref only matters when both request.
    function automatic logic arb_pick(input logic req0, input logic req1, input logic pref);
        if (req0 && req1) begin
            return pref;
        end
        return req1;
    endfunction

endpackage

// File: rtl/ahb_lite_arb_2to1_if.sv
// AHB-Lite bus bundle; master drives the address/data phase, slave answers.
interface ahb_lite_arb_2to1_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [3:0]        hprot;
    logic [2:0]        hburst;
    logic              hmastlock;
    logic [DATA_W-1:0] hwdata;
    logic [DATA_W-1:0] hrdata;
    logic              hready;
    logic              hresp;

    modport master (
        output haddr, htrans, hwrite, hsize, hprot, hburst, hmastlock, hwdata,
        input  hrdata, hready, hresp
    );

    // Upstream adapters issue SINGLE only, so burst/lock are not consumed.
    modport slave (
        input  haddr, htrans, hwrite, hsize, hprot, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/ahb_lite_arb_2to1_req_hold.sv
// Per-port request capture: hold register for a not-yet-issued address phase
// plus the outstanding flag that drives this port's hready back-pressure.
module ahb_lite_arb_2to1_req_hold
    import ahb_lite_arb_2to1_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    htrans,
    input  ahb_addr_req_t live,
    input  logic          granted,
    input  logic          bus_ready,
    input  logic          dp_mine,
    output logic          req,
    output logic          held,
    output logic          hready,
    output ahb_addr_req_t sel
);
    logic          hold_vld;
    ahb_addr_req_t hold_req;
    logic          outstanding;
    logic          live_vld;
    logic          issued;

    assign hready   = !outstanding || (dp_mine && bus_ready);
    assign live_vld = (htrans == HTRANS_NONSEQ) && hready;
    assign issued   = granted && bus_ready;
    assign req      = hold_vld || live_vld;
    assign held     = hold_vld;
    assign sel      = hold_vld ? hold_req : live;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld    <= 1'b0;
            hold_req    <= '0;
            outstanding <= 1'b0;
        end else begin
            // A port with a pending hold is stalled, so live and hold never coexist.
            if (hold_vld) begin
                if (issued) begin
                    hold_vld <= 1'b0;
                end
            end else if (live_vld && !issued) begin
                hold_vld <= 1'b1;
                hold_req <= live;
            end

            // New acceptance wins over completion for back-to-back transfers.
            if (live_vld) begin
                outstanding <= 1'b1;
            end else if (dp_mine && bus_ready) begin
                outstanding <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/ahb_lite_arb_2to1.sv
// Two-master to one-slave AHB-Lite arbiter: live grants pass straight through,
// losers are held and replayed ahead of any new live request.
module ahb_lite_arb_2to1
    import ahb_lite_arb_2to1_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter bit          ROUND_ROBIN = 1'b0,
    parameter int unsigned PRIO_PORT   = 1
) (
    input  logic                hclk_i,
    input  logic                hresetn_i,
    ahb_lite_arb_2to1_if.slave  s0,
    ahb_lite_arb_2to1_if.slave  s1,
    ahb_lite_arb_2to1_if.master m
);
    ahb_addr_req_t     live0, live1, sel0, sel1, gnt_req;
    logic              req0, req1, held0, held1, hready0, hready1;
    logic              gnt_vld, gnt_port, pref;
    logic              addr_lock, lock_port;
    logic              dp_vld, dp_owner, rr_ptr;
    logic              dp_mine0, dp_mine1;
    logic [DATA_W-1:0] wdata_sel;

    assign live0 = '{addr: AHB_ADDR_W'(s0.haddr), write: s0.hwrite, size: s0.hsize, prot: s0.hprot};
    assign live1 = '{addr: AHB_ADDR_W'(s1.haddr), write: s1.hwrite, size: s1.hsize, prot: s1.hprot};

    assign dp_mine0 = dp_vld && !dp_owner;
    assign dp_mine1 = dp_vld &&  dp_owner;

    ahb_lite_arb_2to1_req_hold u_hold0 (
        .clk       (hclk_i),
        .rst_n     (hresetn_i),
        .htrans    (s0.htrans),
        .live      (live0),
        .granted   (gnt_vld && !gnt_port),
        .bus_ready (m.hready),
        .dp_mine   (dp_mine0),
        .req       (req0),
        .held      (held0),
        .hready    (hready0),
        .sel       (sel0)
    );

    ahb_lite_arb_2to1_req_hold u_hold1 (
        .clk       (hclk_i),
        .rst_n     (hresetn_i),
        .htrans    (s1.htrans),
        .live      (live1),
        .granted   (gnt_vld && gnt_port),
        .bus_ready (m.hready),
        .dp_mine   (dp_mine1),
        .req       (req1),
        .held      (held1),
        .hready    (hready1),
        .sel       (sel1)
    );

    // Locked address first, then held losers, then live requests.
    always_comb begin
        pref     = ROUND_ROBIN ? rr_ptr : (PRIO_PORT == 1);
        gnt_vld  = 1'b0;
        gnt_port = 1'b0;
        if (hresetn_i) begin
            if (addr_lock) begin
                gnt_vld  = 1'b1;
                gnt_port = lock_port;
            end else if (held0 || held1) begin
                gnt_vld  = 1'b1;
                gnt_port = arb_pick(held0, held1, pref);
            end else if (req0 || req1) begin
                gnt_vld  = 1'b1;
                gnt_port = arb_pick(req0, req1, pref);
            end
        end
    end

    assign gnt_req   = gnt_port ? sel1 : sel0;
    assign wdata_sel = dp_owner ? s1.hwdata : s0.hwdata;

    assign m.haddr     = gnt_vld ? ADDR_W'(gnt_req.addr) : '0;
    assign m.htrans    = gnt_vld ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign m.hwrite    = gnt_vld && gnt_req.write;
    assign m.hsize     = gnt_vld ? gnt_req.size : '0;
    assign m.hprot     = gnt_vld ? gnt_req.prot : '0;
    assign m.hburst    = HBURST_SINGLE;
    assign m.hmastlock = 1'b0;
    assign m.hwdata    = dp_vld ? wdata_sel : '0;

    assign s0.hrdata = m.hrdata;
    assign s1.hrdata = m.hrdata;
    assign s0.hready = hready0;
    assign s1.hready = hready1;
    assign s0.hresp  = dp_mine0 && m.hresp;
    assign s1.hresp  = dp_mine1 && m.hresp;

    always_ff @(posedge hclk_i or negedge hresetn_i) begin
        if (!hresetn_i) begin
            addr_lock <= 1'b0;
            lock_port <= 1'b0;
            dp_vld    <= 1'b0;
            dp_owner  <= 1'b0;
            rr_ptr    <= 1'b0;
        end else if (m.hready) begin
            addr_lock <= 1'b0;
            dp_vld    <= gnt_vld;
            if (gnt_vld) begin
                dp_owner <= gnt_port;
                rr_ptr   <= ~gnt_port;
            end
        end else begin
            addr_lock <= gnt_vld;
            lock_port <= gnt_port;
        end
    end
endmodule

// File: tb/tb_ahb_lite_arb_2to1.sv
// Directed bench: fixed-priority instance for most scenarios, a round-robin
// instance for the alternating-owner scenario.
module tb_ahb_lite_arb_2to1;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    ahb_lite_arb_2to1_if #(.ADDR_W(32), .DATA_W(32)) s0 ();
    ahb_lite_arb_2to1_if #(.ADDR_W(32), .DATA_W(32)) s1 ();
    ahb_lite_arb_2to1_if #(.ADDR_W(32), .DATA_W(32)) m ();
    ahb_lite_arb_2to1_if #(.ADDR_W(32), .DATA_W(32)) r0 ();
    ahb_lite_arb_2to1_if #(.ADDR_W(32), .DATA_W(32)) r1 ();
    ahb_lite_arb_2to1_if #(.ADDR_W(32), .DATA_W(32)) rm ();

    ahb_lite_arb_2to1 #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(1'b0), .PRIO_PORT(1)) dut (
        .hclk_i(clk), .hresetn_i(rst_n), .s0(s0.slave), .s1(s1.slave), .m(m.master)
    );

    ahb_lite_arb_2to1 #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(1'b1), .PRIO_PORT(1)) dut_rr (
        .hclk_i(clk), .hresetn_i(rst_n), .s0(r0.slave), .s1(r1.slave), .m(rm.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge; inputs change here.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        s0.haddr = '0; s0.htrans = 2'b00; s0.hwrite = 1'b0; s0.hsize = 3'd2; s0.hprot = 4'h3;
        s0.hwdata = '0; s0.hburst = '0; s0.hmastlock = 1'b0;
        s1.haddr = '0; s1.htrans = 2'b00; s1.hwrite = 1'b0; s1.hsize = 3'd2; s1.hprot = 4'h3;
        s1.hwdata = '0; s1.hburst = '0; s1.hmastlock = 1'b0;
        r0.haddr = '0; r0.htrans = 2'b00; r0.hwrite = 1'b0; r0.hsize = 3'd2; r0.hprot = 4'h3;
        r0.hwdata = '0; r0.hburst = '0; r0.hmastlock = 1'b0;
        r1.haddr = '0; r1.htrans = 2'b00; r1.hwrite = 1'b0; r1.hsize = 3'd2; r1.hprot = 4'h3;
        r1.hwdata = '0; r1.hburst = '0; r1.hmastlock = 1'b0;
        m.hrdata = '0; m.hready = 1'b1; m.hresp = 1'b0;
        rm.hrdata = '0; rm.hready = 1'b1; rm.hresp = 1'b0;

        // Reset values
        cyc();
        #1;
        chk("rst_s0_hready", s0.hready, 1);
        chk("rst_s1_hready", s1.hready, 1);
        chk("rst_s0_hresp", s0.hresp, 0);
        chk("rst_m_htrans", m.htrans, 0);
        chk("rst_m_haddr", m.haddr, 0);
        chk("rst_m_hwdata", m.hwdata, 0);
        cyc();
        rst_n = 1'b1;

        // 1: single s1 read, zero wait states
        cyc();
        s1.haddr = 32'h0000_0100; s1.htrans = 2'b10; s1.hwrite = 1'b0;
        #1;
        chk("t1_m_htrans", m.htrans, 2'b10);
        chk("t1_m_haddr", m.haddr, 32'h0000_0100);
        cyc();
        s1.htrans = 2'b00; m.hrdata = 32'hDEAD_BEEF;
        #1;
        chk("t1_s1_hready", s1.hready, 1);
        chk("t1_s1_hrdata", s1.hrdata, 32'hDEAD_BEEF);
        chk("t1_m_idle", m.htrans, 2'b00);

        // 2: simultaneous requests, port 1 has priority
        cyc();
        s0.haddr = 32'h80; s0.htrans = 2'b10;
        s1.haddr = 32'h2000; s1.htrans = 2'b10;
        #1;
        chk("t2_first_addr", m.haddr, 32'h2000);
        cyc();
        s0.htrans = 2'b00; s1.htrans = 2'b00;
        #1;
        chk("t2_second_addr", m.haddr, 32'h80);
        chk("t2_second_trans", m.htrans, 2'b10);
        chk("t2_s0_stalled", s0.hready, 0);
        chk("t2_s1_done", s1.hready, 1);
        cyc();
        m.hready = 1'b0;
        #1;
        chk("t2_s0_wait", s0.hready, 0);
        cyc();
        m.hready = 1'b1;
        #1;
        chk("t2_s0_done", s0.hready, 1);

        // 3: s0 read waited 3 cycles, s1 write arrives during the wait
        cyc();
        s0.haddr = 32'h4000; s0.htrans = 2'b10;
        #1;
        chk("t3_s0_addr", m.haddr, 32'h4000);
        cyc();
        s0.htrans = 2'b00; m.hready = 1'b0;
        s1.haddr = 32'h3000; s1.htrans = 2'b10; s1.hwrite = 1'b1;
        #1;
        chk("t3_s0_wait", s0.hready, 0);
        chk("t3_s1_accepted", s1.hready, 1);
        cyc();
        s1.htrans = 2'b00; s1.hwrite = 1'b0; s1.hwdata = 32'hA5A5_A5A5;
        #1;
        chk("t3_s1_stalled", s1.hready, 0);
        cyc();
        cyc();
        m.hready = 1'b1; m.hrdata = 32'h1234_5678;
        #1;
        chk("t3_s0_done", s0.hready, 1);
        chk("t3_s0_rdata", s0.hrdata, 32'h1234_5678);
        chk("t3_s1_addr", m.haddr, 32'h3000);
        chk("t3_s1_trans", m.htrans, 2'b10);
        chk("t3_s1_write", m.hwrite, 1);
        chk("t3_s1_still_stalled", s1.hready, 0);
        cyc();
        #1;
        chk("t3_hwdata", m.hwdata, 32'hA5A5_A5A5);
        chk("t3_s1_done", s1.hready, 1);
        chk("t3_idle", m.htrans, 2'b00);

        // 4: two-cycle ERROR response on an s0 data phase
        cyc();
        s0.haddr = 32'h5000; s0.htrans = 2'b10;
        cyc();
        s0.htrans = 2'b00; m.hready = 1'b0; m.hresp = 1'b1;
        #1;
        chk("t4_err1_s0_hresp", s0.hresp, 1);
        chk("t4_err1_s0_hready", s0.hready, 0);
        chk("t4_err1_s1_hresp", s1.hresp, 0);
        cyc();
        m.hready = 1'b1;
        #1;
        chk("t4_err2_s0_hresp", s0.hresp, 1);
        chk("t4_err2_s0_hready", s0.hready, 1);
        chk("t4_err2_s1_hresp", s1.hresp, 0);
        cyc();
        m.hresp = 1'b0;
        #1;
        chk("t4_after_hresp", s0.hresp, 0);

        // 6: reset while an s0 request is held
        cyc();
        s0.haddr = 32'h6000; s0.htrans = 2'b10;
        s1.haddr = 32'h7000; s1.htrans = 2'b10;
        cyc();
        s0.htrans = 2'b00; s1.htrans = 2'b00;
        #1;
        chk("t6_held_presented", m.haddr, 32'h6000);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_htrans", m.htrans, 2'b00);
        chk("t6_rst_haddr", m.haddr, 0);
        chk("t6_rst_s0_hready", s0.hready, 1);
        chk("t6_rst_s1_hready", s1.hready, 1);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("t6_no_replay0", m.htrans, 2'b00);
        cyc();
        #1;
        chk("t6_no_replay1", m.htrans, 2'b00);
        chk("t6_s0_hready", s0.hready, 1);

        // 5: round robin, both ports issuing back to back
        cyc();
        r0.haddr = 32'hA00; r0.htrans = 2'b10;
        r1.haddr = 32'hB00; r1.htrans = 2'b10;
        #1;
        chk("t5_xfer0", rm.haddr, 32'hA00);
        cyc();
        r1.htrans = 2'b00;
        r0.haddr = 32'hA04;
        #1;
        chk("t5_r0_ready1", r0.hready, 1);
        chk("t5_xfer1", rm.haddr, 32'hB00);
        cyc();
        r0.htrans = 2'b00;
        r1.haddr = 32'hB04; r1.htrans = 2'b10;
        #1;
        chk("t5_r1_ready2", r1.hready, 1);
        chk("t5_xfer2", rm.haddr, 32'hA04);
        cyc();
        r1.htrans = 2'b00;
        #1;
        chk("t5_xfer3", rm.haddr, 32'hB04);
        chk("t5_xfer3_trans", rm.htrans, 2'b10);
        cyc();
        #1;
        chk("t5_drained", rm.htrans, 2'b00);
        r0.haddr = 32'hA08; r0.htrans = 2'b10;
        cyc();
        r0.haddr = 32'hA0C;
        r1.haddr = 32'hB08; r1.htrans = 2'b10;
        #1;
        chk("t5_tie_after_p0", rm.haddr, 32'hB08);
        cyc();
        r0.htrans = 2'b00; r1.htrans = 2'b00;
        #1;
        chk("t5_tie_loser", rm.haddr, 32'hA0C);
        cyc();
        cyc();
        #1;
        chk("t5_final_idle", rm.htrans, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
